// File: rtl/ex_iter_alu.sv
// Multi-cycle ALU: single-cycle logic ops and bit-serial shifts behind a
// valid/ready handshake, with flush and asynchronous active-low reset.
module ex_iter_alu #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_ctrl,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal,
    output logic            busy
);

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SLL = 4'b0100;
    localparam logic [3:0] ALU_SRL = 4'b0101;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_NE  = 4'b0111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            zero_q, zero_d;
    logic            illegal_q, illegal_d;
    logic [4:0]      cnt_q, cnt_d;
    logic            left_q, left_d;

    logic [XLEN-1:0] alu_res;
    logic            alu_ill;
    logic [4:0]      shamt;
    logic            is_shift;

    assign shamt    = op_b[4:0];
    assign is_shift = (alu_ctrl == ALU_SLL) || (alu_ctrl == ALU_SRL);

    // NOTE: every combinational output gets a default before the case so no latch is inferred.
    always_comb begin
        alu_res = '0;
        alu_ill = 1'b0;
        case (alu_ctrl)
            ALU_AND: alu_res = op_a & op_b;
            ALU_OR:  alu_res = op_a | op_b;
            ALU_ADD: alu_res = op_a + op_b;
            ALU_XOR: alu_res = op_a ^ op_b;
            ALU_SLL: alu_res = op_a << shamt;
            ALU_SRL: alu_res = op_a >> shamt;
            ALU_SUB: alu_res = op_a - op_b;
            ALU_NE:  alu_res = {{(XLEN-1){1'b0}}, (op_a != op_b)};
            default: alu_ill = 1'b1;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        illegal_d = illegal_q;
        cnt_d     = cnt_q;
        left_d    = left_q;

        if (flush) begin
            state_d   = ST_IDLE;
            illegal_d = 1'b0;
            cnt_d     = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        illegal_d = alu_ill;
                        // Non-zero shifts are done one bit per cycle from op_a.
                        if (is_shift && (shamt != 5'd0)) begin
                            result_d = op_a;
                            left_d   = (alu_ctrl == ALU_SLL);
                            cnt_d    = shamt;
                            state_d  = ST_SHIFT;
                        end else begin
                            result_d = alu_res;
                            state_d  = ST_DONE;
                        end
                    end
                end
                ST_SHIFT: begin
                    result_d = left_q ? (result_q << 1) : (result_q >> 1);
                    cnt_d    = cnt_q - 5'd1;
                    if (cnt_q == 5'd1) begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_d   = ST_IDLE;
                        illegal_d = 1'b0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        zero_d = (result_d == '0);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            result_q  <= '0;
            zero_q    <= 1'b1;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
            left_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
            left_q    <= left_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_ex_iter_alu.sv
// Self-checking bench for ex_iter_alu: directed vector table, handshake and
// flush/reset corner sequences, then random ops against a reference model.
module tb_ex_iter_alu;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_ctrl;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        illegal;
    logic        busy;

    int total = 0;
    int bad   = 0;

    ex_iter_alu #(.XLEN(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_ctrl  (alu_ctrl),
        .op_a      (op_a),
        .op_b      (op_b),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .illegal   (illegal),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        ill;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model straight from the operation definitions.
    function automatic void model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic ill, output int lat);
        int sh;
        sh  = int'(b[4:0]);
        ill = 1'b0;
        lat = 1;
        case (c)
            4'd0: r = a & b;
            4'd1: r = a | b;
            4'd2: r = a + b;
            4'd3: r = a ^ b;
            4'd4: begin r = a << sh; lat = (sh == 0) ? 1 : sh + 1; end
            4'd5: begin r = a >> sh; lat = (sh == 0) ? 1 : sh + 1; end
            4'd6: r = a - b;
            4'd7: r = (a != b) ? 32'd1 : 32'd0;
            default: begin r = 32'd0; ill = 1'b1; end
        endcase
    endfunction

    task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] r, input logic ill, input int lat,
                          input int stall, input string tag);
        int cycles;
        bit busy_ok;
        in_valid  = 1'b1;
        alu_ctrl  = c;
        op_a      = a;
        op_b      = b;
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        alu_ctrl = 4'($urandom);
        op_a     = $urandom;
        op_b     = $urandom;
        cycles   = 1;
        busy_ok  = 1'b1;
        while (!out_valid && cycles < 40) begin
            if (!busy || in_ready) busy_ok = 1'b0;
            step();
            cycles++;
        end
        check({tag, " latency"}, cycles, lat);
        if (lat > 1) check({tag, " busy during shift"}, busy_ok, 1);
        check({tag, " result"}, result, r);
        check({tag, " zero"}, zero, (r == 32'd0));
        check({tag, " illegal"}, illegal, ill);
        if (stall > 0) begin
            repeat (stall) step();
            check({tag, " held result"}, result, r);
            check({tag, " held valid"}, out_valid, 1);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, " idle valid"}, out_valid, 0);
        check({tag, " idle ready"}, in_ready, 1);
        check({tag, " idle illegal"}, illegal, 0);
        check({tag, " kept result"}, result, r);
    endtask

    initial begin
        logic [3:0]  rc;
        logic [31:0] ra, rb, rr;
        logic        ri;
        int          rl;

        vecs[0]  = '{4'b0010, 32'hFFFF_FFFF, 32'd1,        32'd0,        1'b0, 1};
        vecs[1]  = '{4'b0100, 32'd1,         32'd31,       32'h8000_0000, 1'b0, 32};
        vecs[2]  = '{4'b1010, 32'h1234_5678, 32'h9,        32'd0,        1'b1, 1};
        vecs[3]  = '{4'b0111, 32'd7,         32'd7,        32'd0,        1'b0, 1};
        vecs[4]  = '{4'b0111, 32'd7,         32'd8,        32'd1,        1'b0, 1};
        vecs[5]  = '{4'b0000, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0, 1};
        vecs[6]  = '{4'b0001, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0, 1'b0, 1};
        vecs[7]  = '{4'b0011, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0, 1'b0, 1};
        vecs[8]  = '{4'b0101, 32'h8000_0000, 32'd4,        32'h0800_0000, 1'b0, 5};
        vecs[9]  = '{4'b0100, 32'h0000_1234, 32'd32,       32'h0000_1234, 1'b0, 1};
        vecs[10] = '{4'b0110, 32'd0,         32'd1,        32'hFFFF_FFFF, 1'b0, 1};
        vecs[11] = '{4'b1111, 32'd0,         32'd0,        32'd0,        1'b1, 1};

        rst_n = 1'b0; in_valid = 1'b0; alu_ctrl = '0; op_a = '0; op_b = '0;
        flush = 1'b0; out_ready = 1'b0;
        #2;
        check("reset in_ready", in_ready, 1);
        check("reset busy", busy, 0);
        check("reset out_valid", out_valid, 0);
        check("reset result", result, 0);
        check("reset illegal", illegal, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].ctrl, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].ill,
                   vecs[i].lat, i % 3, $sformatf("vec%0d", i));
        end

        // Backpressure: SUB 5-3 stalled for four cycles.
        run_op(4'b0110, 32'd5, 32'd3, 32'd2, 1'b0, 1, 4, "sub stall");

        // Flush on cycle 3 of SRL by 10 with a competing offer.
        in_valid = 1'b1; alu_ctrl = 4'b0101; op_a = 32'hF000_0000; op_b = 32'd10;
        step();
        in_valid = 1'b0;
        step();
        step();
        check("flush pre busy", busy, 1);
        flush = 1'b1; in_valid = 1'b1; alu_ctrl = 4'b0010; op_a = 32'd1; op_b = 32'd2;
        step();
        check("flush idle busy", busy, 0);
        check("flush idle ready", in_ready, 1);
        check("flush no valid", out_valid, 0);
        flush = 1'b0; in_valid = 1'b0;
        step();
        check("flush offer dropped busy", busy, 0);
        check("flush offer dropped valid", out_valid, 0);

        // Flush in IDLE blocks acceptance.
        flush = 1'b1; in_valid = 1'b1; alu_ctrl = 4'b0010;
        step();
        check("flush idle accept", busy, 0);
        flush = 1'b0; in_valid = 1'b0;

        // Flush in DONE discards an illegal result under backpressure.
        in_valid = 1'b1; alu_ctrl = 4'b1100;
        step();
        in_valid = 1'b0;
        check("done before flush", out_valid, 1);
        check("done illegal", illegal, 1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush done valid", out_valid, 0);
        check("flush done illegal", illegal, 0);

        // Asynchronous reset in the middle of a shift.
        in_valid = 1'b1; alu_ctrl = 4'b0100; op_a = 32'd1; op_b = 32'd20;
        step();
        in_valid = 1'b0;
        step();
        step();
        #3;
        rst_n = 1'b0;
        #1;
        check("async rst busy", busy, 0);
        check("async rst ready", in_ready, 1);
        check("async rst result", result, 0);
        check("async rst valid", out_valid, 0);
        check("async rst illegal", illegal, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        begin
            bit saw_valid;
            saw_valid = 1'b0;
            repeat (25) begin
                step();
                if (out_valid) saw_valid = 1'b1;
            end
            check("abandoned op valid", saw_valid, 0);
        end
        run_op(4'b0111, 32'd7, 32'd7, 32'd0, 1'b0, 1, 0, "ne after reset");

        for (int n = 0; n < 40; n++) begin
            rc = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = $urandom;
            if (n % 4 == 0) ra = 32'd0;
            model(rc, ra, rb, rr, ri, rl);
            run_op(rc, ra, rb, rr, ri, rl, int'($urandom_range(0, 2)), $sformatf("rand%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
